mem_port_arbiter: RTL

Arbitrates the single unified memory port of the multicycle RISC-V core between the instruction-fetch requester and the load/store requester. It sits between the control/datapath and the memory. It latches one request per transaction and drives the memory interface from registers. It tolerates wait states, returns read data with a one-cycle acknowledge, and aborts stalled transactions with an error.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbiter for the single unified memory port of the multicycle
//               RISC-V core. The instruction-fetch and load/store requesters
//               share this port. One request is latched per transaction, and
//               the memory interface is driven from registers for the whole
//               access. The arbiter tolerates wait states and returns read
//               data with a one-cycle acknowledge. A stalled access is
//               aborted with memErr after TIMEOUT busy cycles.
//
// Ports       : CLK, RES        clock, synchronous active-high reset
//               iReq/iAddr      fetch request (held until iAck)
//               iAck/iRdata     fetch completion pulse and fetched word
//               dReq/dWe/dAddr/dWdata/dBe
//                               data request (held until dAck)
//               dAck/dRdata     data completion pulse and load data
//               memEn/memWe/memAddr/memWdata/memBe
//                               registered memory command
//               memRdata/memReady
//                               memory response
//               memErr          abort flag, valid together with iAck/dAck
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic              iAck,
    output logic [DATA_W-1:0] iRdata,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    input  logic [3:0]        dBe,
    output logic              dAck,
    output logic [DATA_W-1:0] dRdata,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    output logic [3:0]        memBe,
    input  logic [DATA_W-1:0] memRdata,
    input  logic              memReady,
    output logic              memErr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2
    } state_t;

    // Counter value at which the next stalled busy cycle is the last one.
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic       r_last_d;   // 1: data was the last completed grant
    logic [7:0] r_cnt;      // busy cycles spent without memReady

    logic w_i_elig;
    logic w_d_elig;
    logic w_grant_i;
    logic w_grant_d;
    logic w_timeout;

    // A requester whose ack is high this cycle is still holding its old
    // request, so it is masked to avoid serving that request a second time.
    assign w_i_elig  = iReq & ~iAck;
    assign w_d_elig  = dReq & ~dAck;
    // On a tie the requester that was not granted last wins.
    assign w_grant_i = w_i_elig & (~w_d_elig | r_last_d);
    assign w_grant_d = w_d_elig & ~w_grant_i;
    assign w_timeout = (r_cnt == c_TO_LAST);

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state  <= S_IDLE;
            r_last_d <= 1'b1;
            r_cnt    <= 8'd0;
            iAck     <= 1'b0;
            dAck     <= 1'b0;
            memErr   <= 1'b0;
            memEn    <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            memBe    <= 4'h0;
            iRdata   <= '0;
            dRdata   <= '0;
        end else begin
            // Acks and the error flag are single-cycle pulses.
            iAck   <= 1'b0;
            dAck   <= 1'b0;
            memErr <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_grant_i) begin
                        r_state  <= S_BUSY_I;
                        r_cnt    <= 8'd0;
                        memEn    <= 1'b1;
                        memWe    <= 1'b0;
                        memAddr  <= iAddr;
                        memWdata <= '0;
                        memBe    <= 4'hF;
                    end else if (w_grant_d) begin
                        r_state  <= S_BUSY_D;
                        r_cnt    <= 8'd0;
                        memEn    <= 1'b1;
                        memWe    <= dWe;
                        memAddr  <= dAddr;
                        memWdata <= dWdata;
                        memBe    <= dWe ? dBe : 4'hF;
                    end
                end

                S_BUSY_I, S_BUSY_D: begin
                    // memReady has priority over an expiring timeout.
                    if (memReady) begin
                        r_state <= S_IDLE;
                        memEn   <= 1'b0;
                        if (r_state == S_BUSY_I) begin
                            iAck     <= 1'b1;
                            iRdata   <= memRdata;
                            r_last_d <= 1'b0;
                        end else begin
                            dAck     <= 1'b1;
                            r_last_d <= 1'b1;
                            if (!memWe) begin
                                dRdata <= memRdata;
                            end
                        end
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                        memEn   <= 1'b0;
                        memErr  <= 1'b1;
                        if (r_state == S_BUSY_I) begin
                            iAck <= 1'b1;
                        end else begin
                            dAck <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    memEn   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
